cpu_io_bridge: RTL and testbench
================================

Name: cpu_io_bridge

Overview:
- Sits directly downstream and upstream of the CPU top level's GPIO pair (y1/y2 out, x1/x2 in).
- Converts the CPU's toggle-style GPIO signalling into valid/ready streams for external peripherals.
- Outbound: each toggle of y1 pushes the y2 word into a small FIFO, which drains on a valid/ready port.
- Inbound: a valid/ready word is latched onto x2 and x1 is toggled. After each accept, in_ready is throttled for a fixed hold window so software has time to read the word.

Parameters:
- DATA_W, 30, payload width; matches the CPU GPIO word width.
- FIFO_DEPTH, 4, outbound FIFO entries; must be a power of 2, minimum 2.
- HOLD_CYCLES, 16, number of cycles in_ready stays low after each inbound accept; minimum 1.

Ports:
- clk  in  1  system clock, same clock as the CPU.
- rst  in  1  asynchronous, active-high reset.
- cpu_y1  in  1  outbound toggle from the CPU; every edge is one new word.
- cpu_y2  in  DATA_W  outbound payload, valid in the same cycle as the toggle.
- cpu_x1  out  1  inbound toggle to the CPU; every edge is one new word.
- cpu_x2  out  DATA_W  inbound payload to the CPU.
- out_valid  out  1  outbound FIFO not empty.
- out_data  out  DATA_W  outbound FIFO head word.
- out_ready  in  1  external consumer accepts the head word.
- in_valid  in  1  external producer presents a word.
- in_data  in  DATA_W  external inbound word.
- in_ready  out  1  bridge able to accept an inbound word.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current outbound occupancy, range 0..FIFO_DEPTH.
- ovf_sticky  out  1  at least one outbound word has been dropped since reset.

Behaviour:
- Reset (asynchronous, active-high) clears: y1_q=0, rd/wr pointers=0, fifo_level=0, ovf_sticky=0, cpu_x1=0, cpu_x2=0, inbound FSM=IDLE, hold counter=0.
  - Resulting output values: out_valid=0, out_data=0 (storage cleared), in_ready=1.
- Reset mid-operation discards FIFO contents and any hold window in progress.
- The CPU resets its y1 from the same rst, so no spurious toggle appears at reset release.
- Outbound toggle detection:
  - y1_q <= cpu_y1 on every cycle.
  - push = (cpu_y1 != y1_q); cpu_y2 is sampled in that same cycle.
  - No synchroniser: both sides are on the same clock and driven by registers.
- Outbound FIFO:
  - First-word-fall-through: out_data = mem[rd_ptr], and out_valid = (level != 0).
  - pop = out_valid && out_ready.
  - Latency: a toggle sampled at edge k is written at edge k; out_valid is high after edge k.
- Full / empty rules:
  - Full with no pop: the push is dropped and ovf_sticky sets. It stays set until rst.
  - Full with pop in the same cycle: the push is accepted and level stays at FIFO_DEPTH.
  - Empty with push and pop in the same cycle: no pop, since out_valid=0; the push lands.
  - Pointers wrap modulo FIFO_DEPTH. Level is incremented or decremented by (push_ok - pop).
- Inbound FSM, two states; in_ready = (state==IDLE):
  - IDLE, in_valid=1: at the edge, cpu_x2 <= in_data, cpu_x1 <= ~cpu_x1, cnt <= HOLD_CYCLES-1, go to HOLD.
  - HOLD, cnt != 0: cnt <= cnt-1.
  - HOLD, cnt == 0: go to IDLE.
  - in_ready is therefore low for exactly HOLD_CYCLES cycles after each accept. Back-to-back accepts are spaced HOLD_CYCLES+1 cycles apart.
  - in_data is ignored while in HOLD; the producer must keep in_valid and in_data stable until in_ready.
- Outbound and inbound paths are fully independent; simultaneous events on both sides need no arbitration.

Decomposition:
- Shared package io_bridge_pkg holds:
  - DATA_W default constant.
  - Inbound state encoding (IO_IDLE=1'b0, IO_HOLD=1'b1).
  - Counter width function clog2.
- One sub-module, io_sync_fifo: parameters DATA_W and DEPTH; ports push, din, pop, dout, level, full, empty.
  - It uses the same asynchronous active-high reset.
- Toggle detection, overflow flag and inbound FSM live in cpu_io_bridge.

Test Plan:
- Reset, then toggle cpu_y1 0->1 with cpu_y2=30'h0000_0ABC and out_ready=0.
  -> Next cycle: out_valid=1, out_data=30'h0000_0ABC, fifo_level=1.
- With out_ready=0, make 5 toggles carrying payloads 1..5 (FIFO_DEPTH=4).
  -> fifo_level=4 and ovf_sticky=1.
  -> Then draining with out_ready=1 yields 1,2,3,4 in order, then out_valid=0.
- With the FIFO full, toggle y1 (payload 9) in the same cycle as out_ready=1.
  -> Head pops, 9 is accepted, level stays 4, ovf_sticky unchanged, 9 drains last.
- Hold in_valid=1, in_data=30'h1234567 from IDLE.
  -> After the edge: cpu_x2=30'h1234567, cpu_x1 toggles to 1, in_ready=0 for 16 cycles, then 1.
  -> Changing in_data to 30'h2 during HOLD has no effect until IDLE; the second accept toggles cpu_x1 to 0.
- Assert rst mid-HOLD with 2 entries queued.
  -> Immediately: in_ready=1, out_valid=0, fifo_level=0, cpu_x1=0, cpu_x2=0, ovf_sticky=0.

Source files
------------

// File: rtl/io_bridge_pkg.sv
// Shared constants, inbound state encoding and width helper for the CPU I/O bridge.
package io_bridge_pkg;

    localparam int IO_DATA_W = 30;

    typedef enum logic {
        IO_IDLE = 1'b0,
        IO_HOLD = 1'b1
    } io_state_e;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO lands only if a pop frees a slot.
module io_sync_fifo
    import io_bridge_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_W-1:0]      din,
    input  logic                   pop,
    output logic [DATA_W-1:0]      dout,
    output logic [clog2(DEPTH):0]  level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       level_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Qualify push/pop against occupancy; a simultaneous pop frees room for the push.
    always_comb begin
        full      = (level_r == (AW+1)'(DEPTH));
        empty     = (level_r == {(AW+1){1'b0}});
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign level = level_r;

endmodule

// File: rtl/cpu_io_bridge.sv
// Bridges the CPU's toggle-style GPIO pair to valid/ready streams: y1 edges feed an outbound FIFO,
// inbound words are latched onto x2 with an x1 toggle and then in_ready is held low for a read window.
module cpu_io_bridge
    import io_bridge_pkg::*;
#(
    parameter int DATA_W      = IO_DATA_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cpu_y1,
    input  logic [DATA_W-1:0]           cpu_y2,
    output logic                        cpu_x1,
    output logic [DATA_W-1:0]           cpu_x2,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    input  logic                        out_ready,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        ovf_sticky
);

    localparam int CNT_W = clog2(HOLD_CYCLES + 1);

    logic              y1_q_r;
    logic              ovf_r;
    logic              push_s;
    logic              pop_s;
    logic              drop_s;
    logic              full_s;
    logic              empty_s;
    io_state_e         state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              cpu_x1_r;
    logic [DATA_W-1:0] cpu_x2_r;
    logic              in_ready_r;

    // Each y1 edge is one outbound word; a push into a full FIFO without a pop is lost.
    always_comb begin
        push_s = (cpu_y1 != y1_q_r);
        pop_s  = !empty_s && out_ready;
        drop_s = push_s && full_s && !pop_s;
    end

    // Toggle history and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y1_q_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            y1_q_r <= cpu_y1;
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    io_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (cpu_y2),
        .pop   (pop_s),
        .dout  (out_data),
        .level (fifo_level),
        .full  (full_s),
        .empty (empty_s)
    );

    // Inbound accept and hold window; in_ready is kept as a register mirroring state == IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IO_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            cpu_x1_r   <= 1'b0;
            cpu_x2_r   <= {DATA_W{1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            case (state_r)
                IO_IDLE: begin
                    if (in_valid) begin
                        cpu_x2_r   <= in_data;
                        cpu_x1_r   <= ~cpu_x1_r;
                        cnt_r      <= CNT_W'(HOLD_CYCLES - 1);
                        state_r    <= IO_HOLD;
                        in_ready_r <= 1'b0;
                    end
                end
                IO_HOLD: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        state_r    <= IO_IDLE;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IO_IDLE;
                    in_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign out_valid  = !empty_s;
    assign ovf_sticky = ovf_r;
    assign cpu_x1     = cpu_x1_r;
    assign cpu_x2     = cpu_x2_r;
    assign in_ready   = in_ready_r;

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Self-checking bench for cpu_io_bridge: directed vector table, inbound/reset sequences, randomized model run.
module tb_cpu_io_bridge;

    localparam int DATA_W = 30;
    localparam int DEPTH  = 4;
    localparam int HOLD   = 16;

    logic              clk;
    logic              rst;
    logic              cpu_y1;
    logic [DATA_W-1:0] cpu_y2;
    logic              cpu_x1;
    logic [DATA_W-1:0] cpu_x2;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [2:0]        fifo_level;
    logic              ovf_sticky;

    int errors = 0;
    int checks = 0;

    cpu_io_bridge #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_y1     (cpu_y1),
        .cpu_y2     (cpu_y2),
        .cpu_x1     (cpu_x1),
        .cpu_x2     (cpu_x2),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .fifo_level (fifo_level),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: queue of words, sticky flag, inbound word and remaining hold cycles.
    logic [DATA_W-1:0] mq[$];
    logic              m_prev_y1;
    logic              m_ovf;
    logic              m_x1;
    logic [DATA_W-1:0] m_x2;
    int                m_hold;

    typedef struct {
        logic              y1;
        logic [DATA_W-1:0] y2;
        logic              ordy;
        logic              ev;
        logic [DATA_W-1:0] ed;
        logic [2:0]        el;
        logic              eo;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_prev_y1 = 1'b0;
        m_ovf     = 1'b0;
        m_x1      = 1'b0;
        m_x2      = '0;
        m_hold    = 0;
    endtask

    task automatic model_edge();
        logic push;
        push = (cpu_y1 != m_prev_y1);
        m_prev_y1 = cpu_y1;
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(cpu_y2);
            else m_ovf = 1'b1;
        end
        if (m_hold == 0) begin
            if (in_valid) begin
                m_x2   = in_data;
                m_x1   = ~m_x1;
                m_hold = HOLD;
            end
        end else begin
            m_hold--;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cpu_y1    = 1'b0;
        cpu_y2    = '0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk({tag, ".data"}, 32'(out_data), 32'(mq[0]));
        chk({tag, ".level"}, 32'(fifo_level), 32'(mq.size()));
        chk({tag, ".ovf"}, 32'(ovf_sticky), 32'(m_ovf));
        chk({tag, ".x1"}, 32'(cpu_x1), 32'(m_x1));
        chk({tag, ".x2"}, 32'(cpu_x2), 32'(m_x2));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_hold == 0));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 30'h0ABC, 1'b0, 1'b1, 30'h0ABC, 3'd1, 1'b0};
        tbl[1]  = '{1'b1, 30'h0,    1'b1, 1'b0, 30'h0,    3'd0, 1'b0};
        tbl[2]  = '{1'b0, 30'h1,    1'b0, 1'b1, 30'h1,    3'd1, 1'b0};
        tbl[3]  = '{1'b1, 30'h2,    1'b0, 1'b1, 30'h1,    3'd2, 1'b0};
        tbl[4]  = '{1'b0, 30'h3,    1'b0, 1'b1, 30'h1,    3'd3, 1'b0};
        tbl[5]  = '{1'b1, 30'h4,    1'b0, 1'b1, 30'h1,    3'd4, 1'b0};
        tbl[6]  = '{1'b0, 30'h5,    1'b0, 1'b1, 30'h1,    3'd4, 1'b1};
        tbl[7]  = '{1'b0, 30'h0,    1'b1, 1'b1, 30'h2,    3'd3, 1'b1};
        tbl[8]  = '{1'b0, 30'h0,    1'b1, 1'b1, 30'h3,    3'd2, 1'b1};
        tbl[9]  = '{1'b0, 30'h0,    1'b1, 1'b1, 30'h4,    3'd1, 1'b1};
        tbl[10] = '{1'b0, 30'h0,    1'b1, 1'b0, 30'h0,    3'd0, 1'b1};
        tbl[11] = '{1'b1, 30'h5,    1'b0, 1'b1, 30'h5,    3'd1, 1'b1};
        tbl[12] = '{1'b0, 30'h6,    1'b0, 1'b1, 30'h5,    3'd2, 1'b1};
        tbl[13] = '{1'b1, 30'h7,    1'b0, 1'b1, 30'h5,    3'd3, 1'b1};
        tbl[14] = '{1'b0, 30'h8,    1'b0, 1'b1, 30'h5,    3'd4, 1'b1};
        tbl[15] = '{1'b1, 30'h9,    1'b1, 1'b1, 30'h6,    3'd4, 1'b1};
        tbl[16] = '{1'b1, 30'h0,    1'b1, 1'b1, 30'h7,    3'd3, 1'b1};
        tbl[17] = '{1'b1, 30'h0,    1'b1, 1'b1, 30'h8,    3'd2, 1'b1};
        tbl[18] = '{1'b1, 30'h0,    1'b1, 1'b1, 30'h9,    3'd1, 1'b1};
        tbl[19] = '{1'b1, 30'h0,    1'b1, 1'b0, 30'h0,    3'd0, 1'b1};

        model_reset();
        do_reset();
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.data", 32'(out_data), 32'd0);
        chk("rst.level", 32'(fifo_level), 32'd0);
        chk("rst.ovf", 32'(ovf_sticky), 32'd0);
        chk("rst.x1", 32'(cpu_x1), 32'd0);
        chk("rst.x2", 32'(cpu_x2), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);

        // Outbound vectors: first word, overflow, drain order, full with simultaneous pop.
        for (int i = 0; i < 20; i++) begin
            cpu_y1    = tbl[i].y1;
            cpu_y2    = tbl[i].y2;
            out_ready = tbl[i].ordy;
            step();
            chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("vec%0d.data", i), 32'(out_data), 32'(tbl[i].ed));
            chk($sformatf("vec%0d.level", i), 32'(fifo_level), 32'(tbl[i].el));
            chk($sformatf("vec%0d.ovf", i), 32'(ovf_sticky), 32'(tbl[i].eo));
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
        end
        out_ready = 1'b0;

        // Inbound accept, hold window, ignored in_data change, second accept.
        in_valid = 1'b1;
        in_data  = 30'h1234567;
        step();
        chk("in1.x2", 32'(cpu_x2), 32'h1234567);
        chk("in1.x1", 32'(cpu_x1), 32'd1);
        chk("in1.in_ready", 32'(in_ready), 32'd0);
        in_data = 30'h2;
        for (int i = 1; i < HOLD; i++) begin
            step();
            chk($sformatf("hold%0d.in_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("hold%0d.x2", i), 32'(cpu_x2), 32'h1234567);
        end
        step();
        chk("hold_end.in_ready", 32'(in_ready), 32'd1);
        chk("hold_end.x2", 32'(cpu_x2), 32'h1234567);
        step();
        chk("in2.x2", 32'(cpu_x2), 32'h2);
        chk("in2.x1", 32'(cpu_x1), 32'd0);
        chk("in2.in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Queue two words while in HOLD, then reset asynchronously.
        cpu_y1 = ~cpu_y1;
        cpu_y2 = 30'h11;
        step();
        cpu_y1 = ~cpu_y1;
        cpu_y2 = 30'h22;
        step();
        chk("pre_rst.level", 32'(fifo_level), 32'd2);
        chk("pre_rst.in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("arst.in_ready", 32'(in_ready), 32'd1);
        chk("arst.valid", 32'(out_valid), 32'd0);
        chk("arst.level", 32'(fifo_level), 32'd0);
        chk("arst.x1", 32'(cpu_x1), 32'd0);
        chk("arst.x2", 32'(cpu_x2), 32'd0);
        chk("arst.ovf", 32'(ovf_sticky), 32'd0);
        do_reset();

        // Randomized traffic against the model, with varying consumer pressure.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 1) cpu_y1 = ~cpu_y1;
            cpu_y2    = 30'($urandom());
            out_ready = (i < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = 30'($urandom());
            step();
            chk_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
